// File: rtl/alu_arbiter_if.sv
// Requester-side bus of the ALU arbiter: two request ports plus the
// shared response channel.
interface alu_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
);
    logic [1:0]        req_valid;
    logic [1:0]        req_ready;
    logic [OP_W-1:0]   req_op_0;
    logic [OP_W-1:0]   req_op_1;
    logic [DATA_W-1:0] req_a_0;
    logic [DATA_W-1:0] req_b_0;
    logic [DATA_W-1:0] req_a_1;
    logic [DATA_W-1:0] req_b_1;
    logic [1:0]        rsp_valid;
    logic [1:0]        rsp_ready;
    logic [DATA_W-1:0] rsp_result;
    logic              rsp_zero;
    logic              rsp_err;

    modport master (
        output req_valid, req_op_0, req_op_1,
        output req_a_0, req_b_0, req_a_1, req_b_1,
        output rsp_ready,
        input  req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );

    modport slave (
        input  req_valid, req_op_0, req_op_1,
        input  req_a_0, req_b_0, req_a_1, req_b_1,
        input  rsp_ready,
        output req_ready, rsp_valid, rsp_result, rsp_zero, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter and sequencer around a shared
// combinational ALU: grant, execute one cycle, hold the response.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int OP_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_arbiter_if.slave      bus,
    output logic [DATA_W-1:0] alu_rd1,
    output logic [DATA_W-1:0] alu_rd2,
    output logic [OP_W-1:0]   alu_ctrl,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [OP_W-1:0] OP_ADD = OP_W'(5'b00000);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(5'b00010);
    localparam logic [OP_W-1:0] OP_AND = OP_W'(5'b11100);
    localparam logic [OP_W-1:0] OP_XOR = OP_W'(5'b10000);
    localparam logic [OP_W-1:0] OP_SLL = OP_W'(5'b00100);
    localparam logic [OP_W-1:0] OP_SRL = OP_W'(5'b10100);
    localparam logic [OP_W-1:0] OP_SRA = OP_W'(5'b10110);
    localparam logic [OP_W-1:0] OP_LUI = OP_W'(5'b11111);

    state_t            state;
    state_t            next;
    logic [1:0]        grant;
    logic              prio;
    logic              owner;
    logic [OP_W-1:0]   sel_op;
    logic [DATA_W-1:0] sel_a;
    logic [DATA_W-1:0] sel_b;
    logic [DATA_W-1:0] result_q;
    logic              zero_q;
    logic              err_q;
    logic              unsup;

    function automatic logic is_shift(input logic [OP_W-1:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic logic is_supported(input logic [OP_W-1:0] op);
        logic ok;
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_XOR,
            OP_SLL, OP_SRL, OP_SRA, OP_LUI: ok = 1'b1;
            default:                        ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Grant decode: only in IDLE; prio breaks ties between two requests.
    always_comb begin
        grant = 2'b00;
        if (state == IDLE) begin
            case (bus.req_valid)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = prio ? 2'b10 : 2'b01;
                default: grant = 2'b00;
            endcase
        end
    end

    // Operand mux for the granted requester.
    always_comb begin
        sel_op = grant[1] ? bus.req_op_1 : bus.req_op_0;
        sel_a  = grant[1] ? bus.req_a_1  : bus.req_a_0;
        sel_b  = grant[1] ? bus.req_b_1  : bus.req_b_0;
    end

    assign unsup = !is_supported(alu_ctrl);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next;
    end

    // Next-state logic.
    always_comb begin
        next = state;
        case (state)
            IDLE:    if (grant != 2'b00) next = EXEC;
            EXEC:    next = RESP;
            RESP:    if (bus.rsp_ready[owner]) next = IDLE;
            default: next = IDLE;
        endcase
    end

    // Output logic; req_ready never depends on rsp_ready.
    always_comb begin
        bus.req_ready = grant;
        bus.rsp_valid = 2'b00;
        if (state == RESP) bus.rsp_valid = owner ? 2'b10 : 2'b01;
        busy = (state == EXEC) || (state == RESP);
    end

    // Load ALU inputs, owner and round-robin pointer on a grant.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_rd1  <= '0;
            alu_rd2  <= '0;
            alu_ctrl <= '0;
            owner    <= 1'b0;
            prio     <= 1'b0;
        end else if (grant != 2'b00) begin
            alu_rd1  <= sel_a;
            alu_rd2  <= is_shift(sel_op)
                        ? {{(DATA_W-5){1'b0}}, sel_b[4:0]}
                        : sel_b;
            alu_ctrl <= sel_op;
            owner    <= grant[1];
            prio     <= grant[0];
        end
    end

    // Capture the ALU result at the end of EXEC; bad ops read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_q <= '0;
            zero_q   <= 1'b0;
            err_q    <= 1'b0;
        end else if (state == EXEC) begin
            result_q <= unsup ? '0 : alu_result;
            zero_q   <= unsup ? 1'b1 : alu_zero;
            err_q    <= unsup;
        end
    end

    assign bus.rsp_result = result_q;
    assign bus.rsp_zero   = zero_q;
    assign bus.rsp_err    = err_q;

endmodule
